// File: rtl/io_port_arbiter.sv
// io_port_arbiter: two-requester byte I/O arbiter acting as an AXI4-Lite master to a UART.
// Requester 0 is the core in/out path, requester 1 the boot loader; one transaction at a time.
// Build macro IO_POLL_TIMEOUT_EN bounds status polling to POLL_LIMIT reads (ACK with ERR=1 on expiry).
module io_port_arbiter #(
  parameter int unsigned POLL_LIMIT = 1000,
  parameter logic        RR_INIT    = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WR0,
  input  logic        WR1,
  input  logic [7:0]  WDATA0,
  input  logic [7:0]  WDATA1,
  output logic        ACK0,
  output logic        ACK1,
  output logic [7:0]  RDATA,
  output logic        ERR,
  output logic [3:0]  ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA_AXI,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA_AXI,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STAT_AR = 3'd1,
    STAT_R  = 3'd2,
    RX_AR   = 3'd3,
    RX_R    = 3'd4,
    TX_AWW  = 3'd5,
    TX_B    = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [3:0] ADDR_RX   = 4'h0;
  localparam logic [3:0] ADDR_TX   = 4'h4;
  localparam logic [3:0] ADDR_STAT = 4'h8;

  state_t      state;
  state_t      state_nxt;

  logic        last_gnt;
  logic        gnt_id;
  logic        gnt_wr;
  logic [7:0]  gnt_byte;
  logic        aw_done;
  logic        w_done;

  logic        grant_c;
  logic        grant_id_c;
  logic        stat_ready_c;
  logic        timeout_c;
  logic        aw_done_nxt;
  logic        w_done_nxt;
  logic        ar_hs;
  logic        r_hs;
  logic        aw_hs;
  logic        w_hs;
  logic        b_hs;

  logic [3:0]  araddr_nxt;
  logic        arvalid_nxt;
  logic        rready_nxt;
  logic [3:0]  awaddr_nxt;
  logic        awvalid_nxt;
  logic [31:0] wdata_nxt;
  logic [3:0]  wstrb_nxt;
  logic        wvalid_nxt;
  logic        bready_nxt;
  logic        ack0_nxt;
  logic        ack1_nxt;
  logic        err_nxt;

  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID  & RREADY;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID  & WREADY;
  assign b_hs  = BVALID  & BREADY;

  // Response status and upper read-data bits carry nothing this block needs.
  logic unused_inputs;
  assign unused_inputs = ^{RRESP, BRESP, RDATA_AXI[31:8]};

  // Arbitration: lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_c    = REQ0 | REQ1;
    grant_id_c = REQ1;
    if (REQ0 && REQ1) begin
      grant_id_c = ~last_gnt;
    end
  end

  // Status word readiness: RX byte available for reads, TX not full for writes.
  assign stat_ready_c = gnt_wr ? ~RDATA_AXI[3] : RDATA_AXI[0];

  // Write-channel completion tracking; each channel may finish on its own cycle.
  assign aw_done_nxt = (state == TX_AWW) & (aw_done | aw_hs);
  assign w_done_nxt  = (state == TX_AWW) & (w_done  | w_hs);

`ifdef IO_POLL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(POLL_LIMIT + 1);

  logic [CNT_W-1:0] poll_cnt;

  // Completed status reads in the current transaction; cleared on each grant.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      poll_cnt <= '0;
    end else if (state == IDLE && grant_c) begin
      poll_cnt <= '0;
    end else if (state == STAT_R && r_hs) begin
      poll_cnt <= poll_cnt + CNT_W'(1);
    end
  end

  // The status read now completing is the POLL_LIMIT-th one.
  assign timeout_c = (32'(poll_cnt) + 32'd1) >= POLL_LIMIT;
`else
  logic unused_poll;
  assign unused_poll = ^32'(POLL_LIMIT);
  assign timeout_c   = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_c) state_nxt = STAT_AR;
      STAT_AR: if (ar_hs)   state_nxt = STAT_R;
      STAT_R: begin
        if (r_hs) begin
          if (stat_ready_c) begin
            state_nxt = gnt_wr ? TX_AWW : RX_AR;
          end else if (timeout_c) begin
            state_nxt = DONE;
          end else begin
            state_nxt = STAT_AR;
          end
        end
      end
      RX_AR:   if (ar_hs)   state_nxt = RX_R;
      RX_R:    if (r_hs)    state_nxt = DONE;
      TX_AWW:  if (aw_done_nxt && w_done_nxt) state_nxt = TX_B;
      TX_B:    if (b_hs)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so every port comes straight from a flop.
  always_comb begin
    araddr_nxt  = '0;
    arvalid_nxt = 1'b0;
    rready_nxt  = 1'b0;
    awaddr_nxt  = '0;
    awvalid_nxt = 1'b0;
    wdata_nxt   = '0;
    wstrb_nxt   = '0;
    wvalid_nxt  = 1'b0;
    bready_nxt  = 1'b0;
    ack0_nxt    = 1'b0;
    ack1_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state_nxt)
      STAT_AR: begin
        araddr_nxt  = ADDR_STAT;
        arvalid_nxt = 1'b1;
      end
      RX_AR: begin
        araddr_nxt  = ADDR_RX;
        arvalid_nxt = 1'b1;
      end
      STAT_R, RX_R: rready_nxt = 1'b1;
      TX_AWW: begin
        awaddr_nxt  = ADDR_TX;
        awvalid_nxt = ~aw_done_nxt;
        wdata_nxt   = {24'd0, gnt_byte};
        wstrb_nxt   = 4'b0001;
        wvalid_nxt  = ~w_done_nxt;
      end
      TX_B: bready_nxt = 1'b1;
      DONE: begin
        ack0_nxt = ~gnt_id;
        ack1_nxt = gnt_id;
        err_nxt  = (state == STAT_R);
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA_AXI <= '0;
      WSTRB     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ACK0      <= 1'b0;
      ACK1      <= 1'b0;
      ERR       <= 1'b0;
      RDATA     <= '0;
    end else begin
      ARADDR    <= araddr_nxt;
      ARVALID   <= arvalid_nxt;
      RREADY    <= rready_nxt;
      AWADDR    <= awaddr_nxt;
      AWVALID   <= awvalid_nxt;
      WDATA_AXI <= wdata_nxt;
      WSTRB     <= wstrb_nxt;
      WVALID    <= wvalid_nxt;
      BREADY    <= bready_nxt;
      ACK0      <= ack0_nxt;
      ACK1      <= ack1_nxt;
      ERR       <= err_nxt;
      if (state == RX_R && r_hs) begin
        RDATA <= RDATA_AXI[7:0];
      end
    end
  end

  // Grant bookkeeping: winner, direction and byte latched at grant; write-channel flags.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_gnt <= RR_INIT;
      gnt_id   <= 1'b0;
      gnt_wr   <= 1'b0;
      gnt_byte <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
      if (state == IDLE && grant_c) begin
        last_gnt <= grant_id_c;
        gnt_id   <= grant_id_c;
        gnt_wr   <= grant_id_c ? WR1 : WR0;
        gnt_byte <= grant_id_c ? WDATA1 : WDATA0;
      end
    end
  end

endmodule

// File: tb/tb_io_port_arbiter.sv
// tb_io_port_arbiter: scoreboard bench for io_port_arbiter with a behavioural AXI4-Lite UART.
`timescale 1ns/1ps
module tb_io_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0, WR0 = 1'b0, WR1 = 1'b0;
  logic [7:0]  WDATA0 = '0, WDATA1 = '0;
  logic        ACK0, ACK1, ERR;
  logic [7:0]  RDATA;
  logic [3:0]  ARADDR, AWADDR, WSTRB;
  logic        ARVALID, RREADY, AWVALID, WVALID, BREADY;
  logic [31:0] WDATA_AXI;
  logic        ARREADY = 1'b0, RVALID = 1'b0, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [31:0] RDATA_AXI = '0;
  logic [1:0]  RRESP = 2'b10, BRESP = 2'b11;

  io_port_arbiter #(.POLL_LIMIT(4), .RR_INIT(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .ERR(ERR),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA_AXI(RDATA_AXI), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA_AXI(WDATA_AXI), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard entry: what the next ACK must look like and what the bus must have seen.
  typedef struct {
    logic        id;
    logic        err;
    logic [7:0]  rdata;
    int          n_stat;
    int          n_rx;
    int          n_aw;
    logic [7:0]  wbyte;
  } exp_t;
  exp_t sb_q[$];

  // Slave model state and per-transaction observations
  logic [7:0]  stat_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] r_q[$];
  logic [7:0]  stat_dflt = 8'h01;
  int          aw_lat = 0, w_lat = 0;
  bit          b_stall = 0;
  int          aw_wait = 0, w_wait = 0, b_pend = 0;
  bit          aw_got = 0, w_got = 0;
  bit          aw_prev_v = 0, aw_prev_r = 0, w_prev_v = 0, w_prev_r = 0;
  int          stat_cnt = 0, rx_cnt = 0, aw_tot = 0, b_tot = 0, aw_only = 0;
  logic [3:0]  last_awaddr = '0, last_wstrb = '0;
  logic [31:0] last_wdata = '0;
  logic [7:0]  rdata_model = '0;

  task automatic clear_obs();
    stat_cnt = 0; rx_cnt = 0; aw_tot = 0; b_tot = 0;
    last_awaddr = '0; last_wstrb = '0; last_wdata = '0;
  endtask

  // UART register slave: AR always ready, R one cycle later, AW/W with programmable delay.
  initial begin : slave
    logic [7:0] st;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0; RDATA_AXI = '0;
        r_q.delete(); stat_q.delete(); rx_q.delete();
        aw_wait = 0; w_wait = 0; b_pend = 0; aw_got = 0; w_got = 0;
        aw_prev_v = 0; aw_prev_r = 0; w_prev_v = 0; w_prev_r = 0;
        clear_obs();
        continue;
      end
      if (BVALID) b_pend--;
      RVALID = 0;
      if (RREADY && r_q.size() > 0) begin
        RVALID = 1;
        RDATA_AXI = r_q.pop_front();
      end
      ARREADY = ARVALID;
      if (ARVALID) begin
        if (ARADDR == 4'h8) begin
          stat_cnt++;
          st = stat_dflt;
          if (stat_q.size() > 0) st = stat_q.pop_front();
          r_q.push_back({24'hA5A5A5, st});
        end else if (ARADDR == 4'h0) begin
          rx_cnt++;
          st = 8'hEE;
          if (rx_q.size() > 0) st = rx_q.pop_front();
          r_q.push_back({24'h5A5A5A, st});
        end
      end
      if (aw_prev_v && !aw_prev_r) chk("awvalid_hold", 32'(AWVALID), 32'd1);
      if (w_prev_v && !w_prev_r)   chk("wvalid_hold", 32'(WVALID), 32'd1);
      AWREADY = 0;
      if (AWVALID) begin
        if (aw_wait >= aw_lat) begin
          AWREADY = 1; aw_wait = 0; aw_tot++; last_awaddr = AWADDR; aw_got = 1;
        end else aw_wait++;
      end
      WREADY = 0;
      if (WVALID) begin
        if (w_wait >= w_lat) begin
          WREADY = 1; w_wait = 0; last_wdata = WDATA_AXI; last_wstrb = WSTRB; w_got = 1;
        end else w_wait++;
      end
      if (AWVALID && !WVALID) aw_only++;
      aw_prev_v = AWVALID; aw_prev_r = AWREADY; w_prev_v = WVALID; w_prev_r = WREADY;
      if (aw_got && w_got) begin
        b_pend++; aw_got = 0; w_got = 0;
      end
      BVALID = 0;
      if (BREADY && b_pend > 0 && !b_stall) begin
        BVALID = 1; b_tot++;
      end
    end
  end

  // ACK monitor: pops the scoreboard and compares result and bus activity.
  initial begin : monitor
    bit   prev_ack;
    exp_t e;
    prev_ack = 0;
    forever begin
      @(negedge CLK);
      if (RST_N && (ACK0 || ACK1)) begin
        chk("ack_width", 32'(prev_ack), 32'd0);
        chk("ack_onehot", 32'(ACK0 & ACK1), 32'd0);
        chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("ack_id", 32'(ACK1), 32'(e.id));
          chk("err", 32'(ERR), 32'(e.err));
          chk("rdata", 32'(RDATA), 32'(e.rdata));
          chk("n_stat", stat_cnt, e.n_stat);
          chk("n_rx", rx_cnt, e.n_rx);
          chk("n_aw", aw_tot, e.n_aw);
          chk("n_b", b_tot, e.n_aw);
          if (e.n_aw > 0) begin
            chk("awaddr", 32'(last_awaddr), 32'h4);
            chk("wdata", last_wdata, {24'd0, e.wbyte});
            chk("wstrb", 32'(last_wstrb), 32'h1);
          end
        end
        clear_obs();
      end
      prev_ack = RST_N && (ACK0 || ACK1);
    end
  end

  task automatic expect_txn(input bit id, input bit err, input logic [7:0] rd,
                            input int n_stat, input int n_rx, input int n_aw, input logic [7:0] wb);
    exp_t e;
    e.id = id; e.err = err; e.n_stat = n_stat; e.n_rx = n_rx; e.n_aw = n_aw; e.wbyte = wb;
    if (!err && n_rx > 0) rdata_model = rd;
    e.rdata = rdata_model;
    sb_q.push_back(e);
  endtask

  // One requester: raise, hold until own ACK (bounded), then release.
  task automatic run_req(input bit id, input bit wr, input logic [7:0] data);
    int n;
    n = 0;
    @(negedge CLK);
    if (id) begin REQ1 = 1; WR1 = wr; WDATA1 = data; end
    else    begin REQ0 = 1; WR0 = wr; WDATA0 = data; end
    do begin
      @(negedge CLK);
      n++;
    end while (!(id ? ACK1 : ACK0) && n < 300);
    if (n >= 300) chk(id ? "ack1_timeout" : "ack0_timeout", 32'(id ? ACK1 : ACK0), 32'd1);
    if (id) begin REQ1 = 0; WR1 = 0; WDATA1 = '0; end
    else    begin REQ0 = 0; WR0 = 0; WDATA0 = '0; end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, 32'({ACK0, ACK1, ERR, RDATA, ARADDR, ARVALID, RREADY, AWADDR, AWVALID,
                  WVALID, WSTRB, BREADY}), 32'd0);
    chk({tag, "_wdata"}, WDATA_AXI, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (2) @(negedge CLK);
    chk_reset_outs("reset_outs");
    RST_N = 1;
    @(negedge CLK);

    // Tie after reset: requester 0 first, then 1; and again (alternation)
    rx_q.push_back(8'h11);
    expect_txn(0, 0, 8'h11, 1, 1, 0, 8'h00);
    expect_txn(1, 0, 8'h00, 1, 0, 1, 8'h33);
    fork
      run_req(0, 0, 8'h00);
      run_req(1, 1, 8'h33);
    join
    rx_q.push_back(8'h77);
    expect_txn(0, 0, 8'h00, 1, 0, 1, 8'h66);
    expect_txn(1, 0, 8'h77, 1, 1, 0, 8'h00);
    fork
      run_req(0, 1, 8'h66);
      run_req(1, 0, 8'h00);
    join

    // Simple read on requester 0
    stat_q.push_back(8'h01);
    rx_q.push_back(8'h41);
    expect_txn(0, 0, 8'h41, 1, 1, 0, 8'h00);
    run_req(0, 0, 8'h00);

    // Write with TX-full status twice before space appears
    stat_q.push_back(8'h08); stat_q.push_back(8'h08); stat_q.push_back(8'h00);
    expect_txn(1, 0, 8'h00, 3, 0, 1, 8'h5A);
    run_req(1, 1, 8'h5A);

    // AWREADY three cycles after WREADY
    aw_lat = 3; aw_only = 0;
    expect_txn(0, 0, 8'h00, 1, 0, 1, 8'hC3);
    run_req(0, 1, 8'hC3);
    chk("aw_only_cycles", aw_only, 3);
    aw_lat = 0;

`ifdef IO_POLL_TIMEOUT_EN
    // Status stuck empty: times out after POLL_LIMIT reads, RDATA untouched
    stat_dflt = 8'h00;
    expect_txn(1, 1, 8'h00, 4, 0, 0, 8'h00);
    run_req(1, 0, 8'h00);
    stat_dflt = 8'h01;
`else
    // Long poll with no bound: five empty status reads, then data
    repeat (5) stat_q.push_back(8'h00);
    stat_q.push_back(8'h01);
    rx_q.push_back(8'h9C);
    expect_txn(1, 0, 8'h9C, 6, 1, 0, 8'h00);
    run_req(1, 0, 8'h00);
`endif

    // Reset while waiting for the write response: abandoned, no ACK
    b_stall = 1;
    @(negedge CLK);
    REQ1 = 1; WR1 = 1; WDATA1 = 8'hE7;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!BREADY && n < 100);
    if (n >= 100) chk("bready_timeout", 32'(BREADY), 32'd1);
    RST_N = 0; REQ1 = 0; WR1 = 0; WDATA1 = '0;
    @(negedge CLK);
    chk_reset_outs("midrst_outs");
    @(negedge CLK);
    b_stall = 0;
    rdata_model = '0;
    RST_N = 1;
    repeat (10) @(negedge CLK);

    // Normal service resumes after the abort
    rx_q.push_back(8'h5E);
    expect_txn(0, 0, 8'h5E, 1, 1, 0, 8'h00);
    run_req(0, 0, 8'h00);

    repeat (4) @(negedge CLK);
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
